// File: rtl/pp_pipe_stage.sv
// ---------------------------------------------------------------------------
// PpPipeStage (module pp_pipe_stage)
//
// Purpose:
//   Pipeline stage placed between Wallace-tree reduction levels of the
//   multiplier datapath. It registers a packed partial-product array plus the
//   two operand sideband words, with a valid/ready handshake backed by a
//   2-entry skid buffer (main register M drives the outputs, skid register S
//   catches the one item that can arrive while M is stalled). Includes a
//   synchronous flush, an occupancy count and a saturating stall counter.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous flush, discards held items
//   in_valid   in   upstream item valid
//   in_ready   out  stage can accept this cycle (registered, no path
//                   from out_ready)
//   in_pp      in   packed rows, row i at [i*LANE_W +: LANE_W]
//   in_a/in_b  in   operand sideband words
//   out_valid  out  out_* holds a valid item
//   out_ready  in   downstream accepts this cycle
//   out_pp     out  registered rows
//   out_a/b    out  registered operand words
//   occupancy  out  number of items held (0..2)
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pp_pipe_stage #(
    parameter int LANES  = 64,
    parameter int LANE_W = 8,
    parameter int OP_W   = 64,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_pp,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_pp,
    output logic [OP_W-1:0]         out_a,
    output logic [OP_W-1:0]         out_b,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int PP_W = LANES * LANE_W;

    logic              r_mValid;
    logic [PP_W-1:0]   r_mPp;
    logic [OP_W-1:0]   r_mA;
    logic [OP_W-1:0]   r_mB;

    logic              r_sValid;
    logic [PP_W-1:0]   r_sPp;
    logic [OP_W-1:0]   r_sA;
    logic [OP_W-1:0]   r_sB;

    logic [CNT_W-1:0]  r_stallCnt;

    logic              w_accept;
    logic              w_release;

    // Readiness only depends on the skid register being free, so the
    // upstream never sees a combinational path from out_ready. Reset also
    // blocks acceptance while it is held.
    assign in_ready  = !r_sValid && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_release = r_mValid && out_ready;

    assign out_valid = r_mValid;
    assign out_pp    = r_mPp;
    assign out_a     = r_mA;
    assign out_b     = r_mB;
    assign occupancy = {1'b0, r_mValid} + {1'b0, r_sValid};
    assign stall_cnt = r_stallCnt;

    // Main and skid storage. M always holds the oldest item; S only fills
    // when M is stalled and a new item arrives, and drains into M on the
    // next release, which keeps strict FIFO order. Flush drops the valid
    // bits but leaves payloads alone, and ignores any input that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mValid <= 1'b0;
            r_mPp    <= '0;
            r_mA     <= '0;
            r_mB     <= '0;
            r_sValid <= 1'b0;
            r_sPp    <= '0;
            r_sA     <= '0;
            r_sB     <= '0;
        end else if (flush) begin
            r_mValid <= 1'b0;
            r_sValid <= 1'b0;
        end else if (!r_mValid) begin
            if (w_accept) begin
                r_mValid <= 1'b1;
                r_mPp    <= in_pp;
                r_mA     <= in_a;
                r_mB     <= in_b;
            end
        end else if (w_release) begin
            if (r_sValid) begin
                r_mPp    <= r_sPp;
                r_mA     <= r_sA;
                r_mB     <= r_sB;
                r_sValid <= 1'b0;
            end else if (w_accept) begin
                r_mPp    <= in_pp;
                r_mA     <= in_a;
                r_mB     <= in_b;
            end else begin
                r_mValid <= 1'b0;
            end
        end else if (w_accept) begin
            r_sValid <= 1'b1;
            r_sPp    <= in_pp;
            r_sA     <= in_a;
            r_sB     <= in_b;
        end
    end

    // Stall observability: counts every cycle the output is offered but
    // refused, sticking at all-ones. Only reset clears it so a flush does
    // not hide stall history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (r_mValid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule
